condicionador_botoes: RTL and testbench

//   Conditions raw push-button inputs into clean, single-cycle press pulses for matriz_leds.
//   Per button: 2-FF synchroniser, debounce filter, rising-edge detector, optional auto-repeat.

---
 rtl/condicionador_botoes_pkg.sv | 21 ++
 rtl/condicionador_botoes_canal.sv | 88 ++++++++
 rtl/condicionador_botoes.sv | 58 +++++
 tb/tb_condicionador_botoes.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/condicionador_botoes_pkg.sv
// ============================================================================
// Module  : condicionador_botoes_pkg
// Brief   : Shared constants for the push-button conditioner (botoes_defs).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package condicionador_botoes_pkg;

  localparam int N_BOTOES      = 6;
  localparam int DEBOUNCE_SIM  = 4;
  localparam int DEBOUNCE_FPGA = 50000;  // 1 ms @ 50 MHz

  // Bits needed to hold the values 0..ciclos
  function automatic int largura_cnt(input int ciclos);
    return (ciclos < 1) ? 1 : $clog2(ciclos + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/condicionador_botoes_canal.sv
// ============================================================================
// Module  : condicionador_botoes_canal
// Brief   : One button channel: synchroniser, debounce, press edge, auto-repeat.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module condicionador_botoes_canal
  import condicionador_botoes_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_SIM,
  parameter int REPEAT_CICLOS   = 0,
  parameter bit ATIVO_ALTO      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic estavel,
  output logic evento
);

  localparam int                 C_W_CNT = largura_cnt(DEBOUNCE_CICLOS);
  localparam logic [C_W_CNT-1:0] C_LIM   = C_W_CNT'(DEBOUNCE_CICLOS);

  logic               r_s1;
  logic               r_s2;
  logic               r_estavel;
  logic [C_W_CNT-1:0] r_cnt;
  logic               w_aceita;
  logic               w_subida;

  // A new level is accepted only after it has disagreed with the stable level
  // on every one of the counted cycles; any return to the old level restarts.
  assign w_aceita = (r_s2 != r_estavel) && (r_cnt == C_LIM);
  assign w_subida = w_aceita & r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_estavel <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1 <= ATIVO_ALTO ? raw : ~raw;
      r_s2 <= r_s1;
      if (r_s2 == r_estavel) begin
        r_cnt <= '0;
      end else if (w_aceita) begin
        r_estavel <= r_s2;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign estavel = r_estavel;

  generate
    if (REPEAT_CICLOS > 0) begin : g_repeat
      localparam int                 C_W_REP = largura_cnt(REPEAT_CICLOS);
      localparam logic [C_W_REP-1:0] C_REP   = C_W_REP'(REPEAT_CICLOS - 1);

      logic [C_W_REP-1:0] r_timer;
      logic               w_repete;

      // No repeat on the edge where the button is being released
      assign w_repete = r_estavel & ~w_aceita & (r_timer == C_REP);

      always_ff @(posedge clk) begin
        if (rst || !r_estavel) begin
          r_timer <= '0;
        end else if (w_repete) begin
          r_timer <= '0;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end

      assign evento = w_subida | w_repete;
    end else begin : g_sem_repeat
      assign evento = w_subida;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/condicionador_botoes.sv
// ============================================================================
// Module  : condicionador_botoes
// Brief   : Raw buttons -> clean 1-cycle press pulses for matriz_leds.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module condicionador_botoes
  import condicionador_botoes_pkg::*;
#(
  parameter int N_BOTOES        = condicionador_botoes_pkg::N_BOTOES,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_FPGA,
  parameter int REPEAT_CICLOS   = 0,
  parameter bit ATIVO_ALTO      = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BOTOES-1:0] botoes_raw,
  input  logic                habilita,
  output logic [N_BOTOES-1:0] pulsos,
  output logic [N_BOTOES-1:0] estado_estavel,
  output logic                algum_pulso
);

  logic [N_BOTOES-1:0] w_eventos;
  logic [N_BOTOES-1:0] r_pulsos;

  generate
    for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
      condicionador_botoes_canal #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
        .REPEAT_CICLOS  (REPEAT_CICLOS),
        .ATIVO_ALTO     (ATIVO_ALTO)
      ) u_canal (
        .clk    (clk),
        .rst    (rst),
        .raw    (botoes_raw[i]),
        .estavel(estado_estavel[i]),
        .evento (w_eventos[i])
      );
    end
  endgenerate

  // Masked events are dropped, never held for later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pulsos <= '0;
    end else begin
      r_pulsos <= w_eventos & {N_BOTOES{habilita}};
    end
  end

  assign pulsos      = r_pulsos;
  assign algum_pulso = |r_pulsos;

endmodule

`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
// ============================================================================
// Module  : tb_condicionador_botoes
// Brief   : Scoreboard bench for condicionador_botoes (two configurations).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_condicionador_botoes;
  import condicionador_botoes_pkg::*;

  localparam int N   = N_BOTOES;
  localparam int D   = DEBOUNCE_SIM;
  localparam int R_B = 8;

  typedef struct {
    int         e;
    logic [5:0] v;
  } exp_t;

  typedef struct {
    int         e;
    int         dut;
    logic [5:0] pul;
    logic [5:0] est;
    bit         chk_est;
  } lit_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         habilita;
  logic [N-1:0] raw;
  logic [N-1:0] raw_b;
  logic [N-1:0] pulsos_a, est_a, pulsos_b, est_b;
  logic         alg_a, alg_b;
  bit           fin = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  lit_t q_l[$];

  logic [N-1:0] hist [0:D+2];
  logic [N-1:0] m_est [2];
  int           m_hold [2][N];

  assign raw_b = ~raw;

  always #5 clk = ~clk;

  condicionador_botoes #(
    .N_BOTOES(N), .DEBOUNCE_CICLOS(D), .REPEAT_CICLOS(0), .ATIVO_ALTO(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .botoes_raw(raw), .habilita(habilita),
    .pulsos(pulsos_a), .estado_estavel(est_a), .algum_pulso(alg_a)
  );

  condicionador_botoes #(
    .N_BOTOES(N), .DEBOUNCE_CICLOS(D), .REPEAT_CICLOS(R_B), .ATIVO_ALTO(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .botoes_raw(raw_b), .habilita(habilita),
    .pulsos(pulsos_b), .estado_estavel(est_b), .algum_pulso(alg_b)
  );

  // Reference model: a level is accepted once the last D+1 synchronised samples
  // all disagree with the current stable level; repeats every R cycles of hold.
  always @(posedge clk) begin : model
    logic [N-1:0] h [0:D+2];
    logic [N-1:0] est;
    logic [N-1:0] vec;
    int           hold;
    int           rep;
    bit           flip;
    exp_t         item;
    for (int k = 0; k <= D + 2; k++) h[k] = hist[k];
    if (rst) begin
      for (int k = 0; k <= D + 2; k++) hist[k] <= '0;
      for (int d = 0; d < 2; d++) begin
        m_est[d] <= '0;
        for (int i = 0; i < N; i++) m_hold[d][i] <= 0;
      end
    end else begin
      for (int k = D + 2; k >= 1; k--) h[k] = h[k-1];
      h[0] = raw;
      for (int k = 0; k <= D + 2; k++) hist[k] <= h[k];
      for (int d = 0; d < 2; d++) begin
        rep = (d == 0) ? 0 : R_B;
        est = m_est[d];
        vec = '0;
        for (int i = 0; i < N; i++) begin
          hold = m_hold[d][i];
          flip = 1'b1;
          for (int k = 2; k <= D + 2; k++) if (h[k][i] == est[i]) flip = 1'b0;
          if (flip) begin
            est[i] = ~est[i];
            vec[i] = est[i];
            hold   = 0;
          end else if (est[i]) begin
            hold = hold + 1;
            if (rep > 0 && (hold % rep) == 0) vec[i] = 1'b1;
          end else begin
            hold = 0;
          end
          m_hold[d][i] <= hold;
        end
        m_est[d] <= est;
        if (!habilita) vec = '0;
        if (vec != '0) begin
          item.e = edge_n;
          item.v = vec;
          if (d == 0) q_a.push_back(item);
          else        q_b.push_back(item);
        end
      end
    end
    edge_n <= edge_n + 1;
  end

  task automatic chk(input string name, input int cur, input logic [5:0] got,
                     input logic [5:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h required %h", name, cur, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    int         cur;
    logic [5:0] ea;
    logic [5:0] eb;
    lit_t       l;
    if (edge_n > 0) begin
      cur = edge_n - 1;
      ea  = '0;
      eb  = '0;
      while (q_a.size() > 0 && q_a[0].e < cur) begin
        chk("stale_a", cur, q_a[0].v, 6'h00);
        void'(q_a.pop_front());
      end
      while (q_b.size() > 0 && q_b[0].e < cur) begin
        chk("stale_b", cur, q_b[0].v, 6'h00);
        void'(q_b.pop_front());
      end
      if (q_a.size() > 0 && q_a[0].e == cur) begin
        ea = q_a[0].v;
        void'(q_a.pop_front());
      end
      if (q_b.size() > 0 && q_b[0].e == cur) begin
        eb = q_b[0].v;
        void'(q_b.pop_front());
      end
      chk("pulsos_a", cur, pulsos_a, ea);
      chk("algum_a", cur, {5'd0, alg_a}, {5'd0, ea != '0});
      chk("estavel_a", cur, est_a, m_est[0]);
      chk("pulsos_b", cur, pulsos_b, eb);
      chk("algum_b", cur, {5'd0, alg_b}, {5'd0, eb != '0});
      chk("estavel_b", cur, est_b, m_est[1]);
      while (q_l.size() > 0 && q_l[0].e <= cur) begin
        l = q_l.pop_front();
        if (l.e < cur) begin
          chk("lit_stale", cur, 6'h3F, 6'h00);
        end else if (l.dut == 0) begin
          chk("lit_pulsos_a", cur, pulsos_a, l.pul);
          if (l.chk_est) chk("lit_estavel_a", cur, est_a, l.est);
        end else begin
          chk("lit_pulsos_b", cur, pulsos_b, l.pul);
          if (l.chk_est) chk("lit_estavel_b", cur, est_b, l.est);
        end
      end
      if (fin) begin
        chk("queue_a_empty", cur, 6'(q_a.size()), 6'd0);
        chk("queue_b_empty", cur, 6'(q_b.size()), 6'd0);
        chk("queue_lit_empty", cur, 6'(q_l.size()), 6'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input int e, input int dut, input logic [5:0] pul,
                     input logic [5:0] est, input bit chk_est);
    lit_t l;
    l.e = e; l.dut = dut; l.pul = pul; l.est = est; l.chk_est = chk_est;
    q_l.push_back(l);
  endtask

  initial begin : stim
    int e0;
    rst      = 1'b1;
    habilita = 1'b1;
    raw      = 6'h3F;
    // reset with all buttons held
    lit(0, 0, 6'h00, 6'h00, 1'b1);
    lit(1, 0, 6'h00, 6'h00, 1'b1);
    lit(1, 1, 6'h00, 6'h00, 1'b1);
    tick(2);
    rst = 1'b0;
    lit(edge_n + 5, 0, 6'h00, 6'h00, 1'b1);
    lit(edge_n + 6, 0, 6'h3F, 6'h3F, 1'b1);
    lit(edge_n + 6, 1, 6'h3F, 6'h3F, 1'b1);
    lit(edge_n + 7, 0, 6'h00, 6'h3F, 1'b1);
    tick(12);
    raw = 6'h00;
    tick(12);
    // clean press and release of bit 0
    raw = 6'h01;
    lit(edge_n + 5, 0, 6'h00, 6'h00, 1'b1);
    lit(edge_n + 6, 0, 6'h01, 6'h01, 1'b1);
    tick(12);
    raw = 6'h00;
    lit(edge_n + 5, 0, 6'h00, 6'h01, 1'b1);
    lit(edge_n + 6, 0, 6'h00, 6'h00, 1'b1);
    tick(12);
    // bounce on bit 1
    raw = 6'h02; tick(1);
    raw = 6'h00; tick(1);
    raw = 6'h02; tick(1);
    raw = 6'h00; tick(1);
    raw = 6'h02;
    lit(edge_n + 6, 0, 6'h02, 6'h02, 1'b1);
    tick(12);
    raw = 6'h00;
    tick(12);
    // press completed while masked
    habilita = 1'b0;
    raw      = 6'h04;
    lit(edge_n + 6, 0, 6'h00, 6'h04, 1'b1);
    tick(10);
    habilita = 1'b1;
    tick(5);
    raw = 6'h00;
    tick(12);
    raw = 6'h04;
    lit(edge_n + 6, 0, 6'h04, 6'h04, 1'b1);
    tick(12);
    raw = 6'h00;
    tick(12);
    // auto-repeat on bit 3
    raw = 6'h08;
    e0  = edge_n + 6;
    lit(e0, 0, 6'h08, 6'h08, 1'b1);
    lit(e0, 1, 6'h08, 6'h08, 1'b1);
    lit(e0 + 4, 1, 6'h00, 6'h08, 1'b1);
    lit(e0 + 8, 0, 6'h00, 6'h08, 1'b1);
    lit(e0 + 8, 1, 6'h08, 6'h08, 1'b1);
    lit(e0 + 16, 1, 6'h08, 6'h08, 1'b1);
    lit(e0 + 24, 1, 6'h08, 6'h08, 1'b1);
    lit(e0 + 32, 1, 6'h00, 6'h00, 1'b1);
    tick(30);
    raw = 6'h00;
    tick(15);
    // simultaneous press, then reset mid-hold
    raw = 6'h21;
    lit(edge_n + 6, 0, 6'h21, 6'h21, 1'b1);
    tick(8);
    rst = 1'b1;
    lit(edge_n, 0, 6'h00, 6'h00, 1'b1);
    lit(edge_n, 1, 6'h00, 6'h00, 1'b1);
    tick(1);
    rst = 1'b0;
    lit(edge_n + 5, 0, 6'h00, 6'h00, 1'b1);
    lit(edge_n + 6, 0, 6'h21, 6'h21, 1'b1);
    tick(12);
    raw = 6'h00;
    tick(12);
    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 4) == 0) raw[$urandom_range(0, N - 1)] ^= 1'b1;
      habilita = ($urandom_range(0, 7) != 0);
      rst      = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    rst      = 1'b0;
    habilita = 1'b1;
    raw      = 6'h00;
    tick(20);
    fin = 1'b1;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
